// File: rtl/tia_audio_sched_if.sv
// CPU register-write bus into the TIA audio block.
interface tia_audio_sched_if;
    logic       wr_en;
    logic [5:0] wr_addr;
    logic [7:0] wr_data;

    modport master (output wr_en, output wr_addr, output wr_data);
    modport slave  (input  wr_en, input  wr_addr, input  wr_data);
endinterface

// File: rtl/tia_audio_sched.sv
// TIA audio front end: AUDCx/AUDFx/AUDVx register decode, audio-rate prescaler,
// and one down-counter datapath time-shared between both channels.
module tia_audio_sched #(
    parameter int unsigned AUD_CLK_DIV = 114
) (
    input  logic                clk,
    input  logic                rst_n,
    tia_audio_sched_if.slave    cpu,
    output logic [3:0]          audc0,
    output logic [3:0]          audc1,
    output logic [4:0]          audf0,
    output logic [4:0]          audf1,
    output logic [3:0]          audv0,
    output logic [3:0]          audv1,
    output logic                aud_tick,
    output logic [1:0]          ch_tick,
    output logic                busy
);

    localparam int unsigned PW = (AUD_CLK_DIV > 1) ? $clog2(AUD_CLK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(AUD_CLK_DIV - 1);

    localparam logic [5:0] ADDR_AUDC0 = 6'h15;
    localparam logic [5:0] ADDR_AUDC1 = 6'h16;
    localparam logic [5:0] ADDR_AUDF0 = 6'h17;
    localparam logic [5:0] ADDR_AUDF1 = 6'h18;
    localparam logic [5:0] ADDR_AUDV0 = 6'h19;
    localparam logic [5:0] ADDR_AUDV1 = 6'h1A;

    typedef enum logic [1:0] {IDLE, SERV0, SERV1} state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic          aud_tick_q, aud_tick_d;
    logic          busy_q, busy_d;
    logic [1:0]    ch_tick_q, ch_tick_d;
    logic [4:0]    cnt0_q, cnt0_d;
    logic [4:0]    cnt1_q, cnt1_d;
    logic [3:0]    audc0_q, audc0_d, audc1_q, audc1_d;
    logic [4:0]    audf0_q, audf0_d, audf1_q, audf1_d;
    logic [3:0]    audv0_q, audv0_d, audv1_q, audv1_d;

    logic [4:0]    cnt_cur, audf_cur, cnt_nxt;
    logic          cnt_zero;

    always_comb begin
        audc0_d = audc0_q;
        audc1_d = audc1_q;
        audf0_d = audf0_q;
        audf1_d = audf1_q;
        audv0_d = audv0_q;
        audv1_d = audv1_q;
        if (cpu.wr_en) begin
            case (cpu.wr_addr)
                ADDR_AUDC0: audc0_d = cpu.wr_data[3:0];
                ADDR_AUDC1: audc1_d = cpu.wr_data[3:0];
                ADDR_AUDF0: audf0_d = cpu.wr_data[4:0];
                ADDR_AUDF1: audf1_d = cpu.wr_data[4:0];
                ADDR_AUDV0: audv0_d = cpu.wr_data[3:0];
                ADDR_AUDV1: audv1_d = cpu.wr_data[3:0];
                default: ;
            endcase
        end
    end

    always_comb begin
        presc_d    = (presc_q == PRESC_LAST) ? '0 : presc_q + PW'(1);
        aud_tick_d = (presc_q == PRESC_LAST);
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (aud_tick_q) state_d = SERV0;
            SERV0:   state_d = SERV1;
            SERV1:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    // Shared datapath: reads the live AUDF register, so a write landing in the
    // service cycle is only seen at the following reload.
    always_comb begin
        cnt_cur  = (state_q == SERV1) ? cnt1_q  : cnt0_q;
        audf_cur = (state_q == SERV1) ? audf1_q : audf0_q;
        cnt_zero = (cnt_cur == '0);
        cnt_nxt  = cnt_zero ? audf_cur : cnt_cur - 5'd1;

        cnt0_d    = cnt0_q;
        cnt1_d    = cnt1_q;
        ch_tick_d = '0;
        if (state_q == SERV0) begin
            cnt0_d       = cnt_nxt;
            ch_tick_d[0] = cnt_zero;
        end else if (state_q == SERV1) begin
            cnt1_d       = cnt_nxt;
            ch_tick_d[1] = cnt_zero;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            presc_q    <= '0;
            aud_tick_q <= 1'b0;
            busy_q     <= 1'b0;
            ch_tick_q  <= '0;
            cnt0_q     <= '0;
            cnt1_q     <= '0;
            audc0_q    <= '0;
            audc1_q    <= '0;
            audf0_q    <= '0;
            audf1_q    <= '0;
            audv0_q    <= '0;
            audv1_q    <= '0;
        end else begin
            state_q    <= state_d;
            presc_q    <= presc_d;
            aud_tick_q <= aud_tick_d;
            busy_q     <= busy_d;
            ch_tick_q  <= ch_tick_d;
            cnt0_q     <= cnt0_d;
            cnt1_q     <= cnt1_d;
            audc0_q    <= audc0_d;
            audc1_q    <= audc1_d;
            audf0_q    <= audf0_d;
            audf1_q    <= audf1_d;
            audv0_q    <= audv0_d;
            audv1_q    <= audv1_d;
        end
    end

    assign audc0    = audc0_q;
    assign audc1    = audc1_q;
    assign audf0    = audf0_q;
    assign audf1    = audf1_q;
    assign audv0    = audv0_q;
    assign audv1    = audv1_q;
    assign aud_tick = aud_tick_q;
    assign ch_tick  = ch_tick_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_tia_audio_sched.sv
// Scoreboard bench for tia_audio_sched: a cycle-indexed reference model queues
// expected ch_tick cycles; a negedge monitor compares every DUT output.
module tb_tia_audio_sched;

    localparam int DIV = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    tia_audio_sched_if bus ();

    logic [3:0] audc0, audc1, audv0, audv1;
    logic [4:0] audf0, audf1;
    logic       aud_tick, busy;
    logic [1:0] ch_tick;

    tia_audio_sched #(.AUD_CLK_DIV(DIV)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .cpu      (bus),
        .audc0    (audc0),
        .audc1    (audc1),
        .audf0    (audf0),
        .audf1    (audf1),
        .audv0    (audv0),
        .audv1    (audv1),
        .aud_tick (aud_tick),
        .ch_tick  (ch_tick),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference model state: cycle index since reset release (cycle 0 = first
    // cycle after release), register mirrors, per-channel countdowns.
    int         cyc = 0;
    logic [3:0] m_audc [2];
    logic [4:0] m_audf [2];
    logic [3:0] m_audv [2];
    int         m_cnt  [2];
    int         q0 [$];
    int         q1 [$];

    function automatic bit is_tick(input int c);
        return (c >= DIV) && (c % DIV == 0);
    endfunction

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                cyc = 0;
                for (int k = 0; k < 2; k++) begin
                    m_audc[k] = '0; m_audf[k] = '0; m_audv[k] = '0; m_cnt[k] = 0;
                end
                q0.delete();
                q1.delete();
            end else begin
                cyc = cyc + 1;
                if (bus.wr_en) begin
                    case (bus.wr_addr)
                        6'h15: m_audc[0] = bus.wr_data[3:0];
                        6'h16: m_audc[1] = bus.wr_data[3:0];
                        6'h17: m_audf[0] = bus.wr_data[4:0];
                        6'h18: m_audf[1] = bus.wr_data[4:0];
                        6'h19: m_audv[0] = bus.wr_data[3:0];
                        6'h1A: m_audv[1] = bus.wr_data[3:0];
                        default: ;
                    endcase
                end
                // Channel k is serviced k+1 cycles after an audio tick and fires
                // one cycle after its service when its count has run out.
                for (int k = 0; k < 2; k++) begin
                    if (is_tick(cyc - 1 - k)) begin
                        if (m_cnt[k] == 0) begin
                            m_cnt[k] = int'(m_audf[k]);
                            if (k == 0) q0.push_back(cyc + 1);
                            else        q1.push_back(cyc + 1);
                        end else begin
                            m_cnt[k] = m_cnt[k] - 1;
                        end
                    end
                end
            end
        end
    end

    task automatic check_ch(input int k, input logic fired);
        bit have;
        int exp_c;
        have  = (k == 0) ? (q0.size() > 0) : (q1.size() > 0);
        exp_c = !have ? -1 : ((k == 0) ? q0[0] : q1[0]);
        if (fired) begin
            tests++;
            if (have && exp_c == cyc) begin
                if (k == 0) void'(q0.pop_front());
                else        void'(q1.pop_front());
            end else begin
                fails++;
                $display("FAIL ch_tick[%0d]: got pulse at cycle %0d, next expected cycle %0d", k, cyc, exp_c);
            end
        end else if (have && exp_c <= cyc) begin
            tests++;
            fails++;
            $display("FAIL ch_tick[%0d]: no pulse at cycle %0d, expected one there", k, cyc);
            if (k == 0) void'(q0.pop_front());
            else        void'(q1.pop_front());
        end
    endtask

    initial begin
        logic [25:0] got_r, exp_r;
        logic        exp_b;
        forever begin
            @(negedge clk);
            got_r = {audc0, audc1, audf0, audf1, audv0, audv1};
            exp_r = {m_audc[0], m_audc[1], m_audf[0], m_audf[1], m_audv[0], m_audv[1]};
            tests++;
            if (got_r !== exp_r) begin
                fails++;
                $display("FAIL regs cycle %0d: got %h required %h", cyc, got_r, exp_r);
            end
            tests++;
            if (aud_tick !== is_tick(cyc)) begin
                fails++;
                $display("FAIL aud_tick cycle %0d: got %b required %b", cyc, aud_tick, is_tick(cyc));
            end
            exp_b = is_tick(cyc - 1) || is_tick(cyc - 2);
            tests++;
            if (busy !== exp_b) begin
                fails++;
                $display("FAIL busy cycle %0d: got %b required %b", cyc, busy, exp_b);
            end
            check_ch(0, ch_tick[0]);
            check_ch(1, ch_tick[1]);
        end
    end

    task automatic drive_wr(input logic [5:0] a, input logic [7:0] d);
        bus.wr_en   = 1'b1;
        bus.wr_addr = a;
        bus.wr_data = d;
        @(negedge clk);
        bus.wr_en   = 1'b0;
    endtask

    task automatic wr(input logic [5:0] a, input logic [7:0] d);
        @(negedge clk);
        drive_wr(a, d);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Stops at the negedge of the cycle serving channel k (k+1 cycles after a tick).
    task automatic wait_serv(input int k);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge clk);
            if (is_tick(cyc - 1 - k)) found = 1'b1;
        end
        if (!found) begin
            tests++;
            fails++;
            $display("FAIL wait_serv%0d: service cycle not reached within bound", k);
        end
    endtask

    initial begin
        bus.wr_en   = 1'b0;
        bus.wr_addr = '0;
        bus.wr_data = '0;
        rst_n       = 1'b0;
        idle(3);
        #2 rst_n = 1'b1;
        idle(14);

        wr(6'h17, 8'hFF);
        wr(6'h1A, 8'hA5);
        wr(6'h20, 8'h3C);
        tests++;
        if ({audc0, audc1, audf0, audf1, audv0, audv1} !== {4'h0, 4'h0, 5'd31, 5'd0, 4'h0, 4'h5}) begin
            fails++;
            $display("FAIL decode: got %h %h %h %h %h %h required 0 0 1f 0 0 5",
                     audc0, audc1, audf0, audf1, audv0, audv1);
        end
        idle(10);

        wr(6'h17, 8'h00);
        wr(6'h18, 8'h03);
        idle(80);

        wr(6'h17, 8'h07);
        idle(3 * DIV);
        wr(6'h17, 8'h01);
        idle(60);

        wr(6'h18, 8'h02);
        idle(20);
        wait_serv(1);
        drive_wr(6'h18, 8'h05);
        idle(120);

        wait_serv(0);
        #2 rst_n = 1'b0;
        idle(3);
        #2 rst_n = 1'b1;
        idle(40);

        for (int i = 0; i < 300; i++) begin
            logic [5:0] a;
            idle(int'($urandom_range(0, 7)));
            case ($urandom_range(0, 7))
                0:       a = 6'($urandom_range(0, 63));
                1:       a = 6'h17;
                2:       a = 6'h18;
                default: a = 6'(6'h15 + $urandom_range(0, 5));
            endcase
            if (a == 6'h17 || a == 6'h18) wr(a, 8'($urandom_range(0, 5)));
            else                          wr(a, 8'($urandom));
        end
        idle(150);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
